// File: rtl/imm_gen_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imm_gen_stage_if : decode-side handshake bundle for imm_gen_stage        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface imm_gen_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [2:0]      in_immsrc;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_target;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_immsrc, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_imm, out_target, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_immsrc, in_pc, flush, out_ready,
    output in_ready, out_valid, out_imm, out_target, out_illegal
  );
endinterface
`default_nettype wire

// File: rtl/imm_gen_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imm_gen_stage : registered RISC-V immediate / PC-target generator with   |
// |                 2-entry skid buffer and flush. Rev 1.0                   |
// +--------------------------------------------------------------------------+
module imm_gen_stage #(
  parameter int XLEN    = 32,
  parameter bit ZIMM_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  imm_gen_stage_if.slave  bus
);

  logic [31:0]     instr;
  logic [31:0]     imm32;
  logic            illegal_new;
  logic [XLEN-1:0] imm_new;
  logic [XLEN-1:0] target_new;
  logic            unused_instr_bits;

  assign instr             = bus.in_instr;
  assign unused_instr_bits = ^instr[6:0];

  always_comb begin
    imm32       = '0;
    illegal_new = 1'b0;
    case (bus.in_immsrc)
      3'b000:  imm32 = {{20{instr[31]}}, instr[31:20]};
      3'b001:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'b010:  imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      3'b011:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      3'b100:  imm32 = {instr[31:12], 12'b0};
      3'b101: begin
        if (ZIMM_EN) imm32 = {27'b0, instr[19:15]};
        else         illegal_new = 1'b1;
      end
      default: illegal_new = 1'b1;
    endcase
  end

  // Every format is sign-extended from bit 31 of the 32-bit value; zimm has bit 31 clear.
  assign imm_new    = XLEN'($signed(imm32));
  assign target_new = bus.in_pc + imm_new;

  logic            m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic            m_illegal_q, m_illegal_d, s_illegal_q, s_illegal_d;
  logic [XLEN-1:0] m_imm_q, m_imm_d, s_imm_q, s_imm_d;
  logic [XLEN-1:0] m_target_q, m_target_d, s_target_q, s_target_d;
  logic            accept;
  logic            consume;

  assign accept  = bus.in_valid && !s_valid_q && !bus.flush;
  assign consume = m_valid_q && bus.out_ready;

  always_comb begin
    m_valid_d   = m_valid_q;
    m_imm_d     = m_imm_q;
    m_target_d  = m_target_q;
    m_illegal_d = m_illegal_q;
    s_valid_d   = s_valid_q;
    s_imm_d     = s_imm_q;
    s_target_d  = s_target_q;
    s_illegal_d = s_illegal_q;
    if (bus.flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else begin
      if (consume) begin
        if (s_valid_q) begin
          m_valid_d   = 1'b1;
          m_imm_d     = s_imm_q;
          m_target_d  = s_target_q;
          m_illegal_d = s_illegal_q;
          s_valid_d   = 1'b0;
        end else begin
          m_valid_d = 1'b0;
        end
      end
      // S is only ever full when in_ready is low, so accept never collides with S->M.
      if (accept) begin
        if (!m_valid_q || (consume && !s_valid_q)) begin
          m_valid_d   = 1'b1;
          m_imm_d     = imm_new;
          m_target_d  = target_new;
          m_illegal_d = illegal_new;
        end else begin
          s_valid_d   = 1'b1;
          s_imm_d     = imm_new;
          s_target_d  = target_new;
          s_illegal_d = illegal_new;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q   <= 1'b0;
      m_imm_q     <= '0;
      m_target_q  <= '0;
      m_illegal_q <= 1'b0;
      s_valid_q   <= 1'b0;
      s_imm_q     <= '0;
      s_target_q  <= '0;
      s_illegal_q <= 1'b0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_imm_q     <= m_imm_d;
      m_target_q  <= m_target_d;
      m_illegal_q <= m_illegal_d;
      s_valid_q   <= s_valid_d;
      s_imm_q     <= s_imm_d;
      s_target_q  <= s_target_d;
      s_illegal_q <= s_illegal_d;
    end
  end

  assign bus.in_ready    = !s_valid_q;
  assign bus.out_valid   = m_valid_q;
  assign bus.out_imm     = m_imm_q;
  assign bus.out_target  = m_target_q;
  assign bus.out_illegal = m_illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_imm_gen_stage : RV32 / RV64 / no-zimm instances driven in lock-step,  |
// |                    checked against a queue-based reference. Rev 1.0      |
// +--------------------------------------------------------------------------+
module tb_imm_gen_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_gen_stage_if #(.XLEN(32)) b32 ();
  imm_gen_stage_if #(.XLEN(64)) b64 ();
  imm_gen_stage_if #(.XLEN(32)) bnz ();

  imm_gen_stage #(.XLEN(32), .ZIMM_EN(1'b1)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  imm_gen_stage #(.XLEN(64), .ZIMM_EN(1'b1)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));
  imm_gen_stage #(.XLEN(32), .ZIMM_EN(1'b0)) u_dutnz (.clk(clk), .rst_n(rst_n), .bus(bnz));

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [63:0] pc;
  } beat_t;

  beat_t q[$];
  int total = 0;
  int bad   = 0;
  localparam logic [63:0] M32 = 64'h0000_0000_FFFF_FFFF;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Immediate value as a signed integer, built from field weights.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src, input bit zen);
    longint v;
    v = 0;
    case (src)
      3'd0: begin v = longint'(ins[31:20]); if (v >= 2048) v -= 4096; end
      3'd1: begin v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]); if (v >= 2048) v -= 4096; end
      3'd2: begin
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
          + longint'(ins[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      3'd3: begin
        v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
          + longint'(ins[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      3'd4: begin
        v = longint'(ins[31:12]) * 4096;
        if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000;
      end
      3'd5: v = zen ? longint'(ins[19:15]) : 0;
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic bit ref_ill(input logic [2:0] src, input bit zen);
    return (src >= 3'd6) || (src == 3'd5 && !zen);
  endfunction

  task automatic check_outputs();
    int n;
    logic [63:0] ei, et, ein, etn;
    bit il, iln;
    n = q.size();
    chk("v32", 64'(b32.out_valid), 64'(n > 0));
    chk("v64", 64'(b64.out_valid), 64'(n > 0));
    chk("vnz", 64'(bnz.out_valid), 64'(n > 0));
    chk("rdy32", 64'(b32.in_ready), 64'(n < 2));
    chk("rdy64", 64'(b64.in_ready), 64'(n < 2));
    chk("rdynz", 64'(bnz.in_ready), 64'(n < 2));
    if (n > 0) begin
      il  = ref_ill(q[0].src, 1'b1);
      iln = ref_ill(q[0].src, 1'b0);
      ei  = il  ? 64'd0 : ref_imm(q[0].instr, q[0].src, 1'b1);
      ein = iln ? 64'd0 : ref_imm(q[0].instr, q[0].src, 1'b0);
      et  = q[0].pc + ei;
      etn = q[0].pc + ein;
      chk("imm32", 64'(b32.out_imm), ei & M32);
      chk("tgt32", 64'(b32.out_target), et & M32);
      chk("ill32", 64'(b32.out_illegal), 64'(il));
      chk("imm64", b64.out_imm, ei);
      chk("tgt64", b64.out_target, et);
      chk("ill64", 64'(b64.out_illegal), 64'(il));
      chk("immnz", 64'(bnz.out_imm), ein & M32);
      chk("tgtnz", 64'(bnz.out_target), etn & M32);
      chk("illnz", 64'(bnz.out_illegal), 64'(iln));
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [2:0] src,
                       input logic [63:0] pc, input bit fl, input bit ordy);
    b32.in_valid = v; b32.in_instr = ins; b32.in_immsrc = src; b32.in_pc = pc[31:0];
    b32.flush = fl; b32.out_ready = ordy;
    b64.in_valid = v; b64.in_instr = ins; b64.in_immsrc = src; b64.in_pc = pc;
    b64.flush = fl; b64.out_ready = ordy;
    bnz.in_valid = v; bnz.in_instr = ins; bnz.in_immsrc = src; bnz.in_pc = pc[31:0];
    bnz.flush = fl; bnz.out_ready = ordy;
  endtask

  // Check current state, present new inputs, then advance the model past the coming edge.
  task automatic step(input bit v, input logic [31:0] ins, input logic [2:0] src,
                      input logic [63:0] pc, input bit fl, input bit ordy);
    int n;
    beat_t b;
    @(negedge clk);
    check_outputs();
    drive(v, ins, src, pc, fl, ordy);
    n = q.size();
    if (fl) begin
      q.delete();
    end else begin
      if (n > 0 && ordy) void'(q.pop_front());
      if (v && n < 2) begin
        b.instr = ins; b.src = src; b.pc = pc;
        q.push_back(b);
      end
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 32'h0, 3'd0, 64'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(b32.out_valid), 64'd0);
    chk("rst_imm", b64.out_imm, 64'd0);
    chk("rst_tgt", b64.out_target, 64'd0);
    chk("rst_ill", 64'(b32.out_illegal), 64'd0);
    chk("rst_ready", 64'(b32.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 32'hFFF00093, 3'd0, 64'h100, 1'b0, 1'b1);
    after_edge();
    chk("addi_imm", 64'(b32.out_imm), 64'hFFFF_FFFF);
    chk("addi_tgt", 64'(b32.out_target), 64'h0000_00FF);
    chk("addi_ill", 64'(b32.out_illegal), 64'd0);
    chk("addi_imm64", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);

    step(1'b1, 32'hFE000EE3, 3'd2, 64'h100, 1'b0, 1'b1);
    after_edge();
    chk("beq_imm", 64'(b32.out_imm), 64'hFFFF_FFFC);
    chk("beq_tgt", 64'(b32.out_target), 64'h0000_00FC);

    step(1'b1, 32'h000FD073, 3'd5, 64'h100, 1'b0, 1'b1);
    after_edge();
    chk("zimm_imm", 64'(b32.out_imm), 64'h1F);
    chk("nozimm_ill", 64'(bnz.out_illegal), 64'd1);
    chk("nozimm_imm", 64'(bnz.out_imm), 64'd0);
    chk("nozimm_tgt", 64'(bnz.out_target), 64'h100);

    step(1'b1, 32'h800000B7, 3'd4, 64'h100, 1'b0, 1'b1);
    after_edge();
    chk("lui_imm64", b64.out_imm, 64'hFFFF_FFFF_8000_0000);

    step(1'b0, 32'h0, 3'd0, 64'h0, 1'b0, 1'b1);
    step(1'b1, 32'h00100013, 3'd0, 64'h200, 1'b0, 1'b0);
    step(1'b1, 32'h00200013, 3'd0, 64'h204, 1'b0, 1'b0);
    after_edge();
    chk("stall_ready", 64'(b32.in_ready), 64'd0);
    chk("stall_m_a", 64'(b32.out_imm), 64'd1);
    step(1'b1, 32'h00300013, 3'd0, 64'h208, 1'b0, 1'b0);
    step(1'b1, 32'h00300013, 3'd0, 64'h208, 1'b0, 1'b0);
    step(1'b1, 32'h00300013, 3'd0, 64'h208, 1'b0, 1'b1);
    after_edge();
    chk("drain_b", 64'(b32.out_imm), 64'd2);
    step(1'b1, 32'h00300013, 3'd0, 64'h208, 1'b0, 1'b1);
    after_edge();
    chk("drain_c", 64'(b32.out_imm), 64'd3);
    step(1'b0, 32'h0, 3'd0, 64'h0, 1'b0, 1'b1);

    step(1'b1, 32'h00500013, 3'd0, 64'h300, 1'b0, 1'b0);
    step(1'b1, 32'h00600013, 3'd0, 64'h304, 1'b0, 1'b0);
    step(1'b1, 32'h00700013, 3'd0, 64'h308, 1'b1, 1'b1);
    after_edge();
    chk("flush_valid", 64'(b32.out_valid), 64'd0);
    chk("flush_ready", 64'(b32.in_ready), 64'd1);
    step(1'b0, 32'h0, 3'd0, 64'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 3'd0, 64'h0, 1'b0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        step(1'b1, $urandom, 3'd0, {$urandom, $urandom}, 1'b0, 1'b0);
        step(1'b1, $urandom, 3'd3, {$urandom, $urandom}, 1'b0, 1'b0);
        @(negedge clk);
        check_outputs();
        drive(1'b0, 32'h0, 3'd0, 64'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(b32.out_valid), 64'd0);
        chk("arst_imm", b64.out_imm, 64'd0);
        chk("arst_tgt", 64'(b32.out_target), 64'd0);
        chk("arst_ready", 64'(b64.in_ready), 64'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
      end
      step($urandom_range(0, 9) < 7, $urandom, 3'($urandom_range(0, 7)),
           {$urandom, $urandom}, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
    end
    @(negedge clk);
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
